policy_select: RTL and testbench
================================

POLICY_SELECT -- requirements
Module: policy_select

Interface
REQ-001 The module SHALL have parameter N_ACTIONS, default 9, number of Q-values per decision (2..16).
REQ-002 The module SHALL have parameter Q_WIDTH, default 16, width of each signed two's-complement Q-value.
REQ-003 The module SHALL have parameter IDX_WIDTH, default 4, width of action index (>= clog2(N_ACTIONS)).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a new decision; sampled only in IDLE.
REQ-007 legal  input  N_ACTIONS  legal-action mask, bit i = action i selectable; latched at accepted start.
REQ-008 q_valid  input  1  q_data valid this cycle.
REQ-009 q_data  input  Q_WIDTH  Q-value for current index, presented in order 0..N_ACTIONS-1.
REQ-010 q_ready  output  1  module accepts q_data this cycle.
REQ-011 busy  output  1  high in SCAN and DONE.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 action  output  IDX_WIDTH  selected action index, held until next start.
REQ-014 action_q  output  Q_WIDTH  Q-value of selected action, held until next start.
REQ-015 no_legal  output  1  latched mask was all zero; held until next start.

Function
REQ-016 FSM states SHALL be IDLE, SCAN, DONE; IDLE->SCAN on start, SCAN->DONE on acceptance of beat N_ACTIONS-1, DONE->IDLE unconditionally next cycle.
REQ-017 On IDLE->SCAN the module SHALL latch legal, clear index counter, clear best_valid; start while busy SHALL be ignored.
REQ-018 q_ready SHALL equal (state==SCAN); a beat is accepted iff q_valid && q_ready; counter advances only on accepted beats, stalls of any length allowed.
REQ-019 On accepted beat i with legal[i]=1, best SHALL update when !best_valid or q_data > best (signed, strict), so ties resolve to the lowest index.
REQ-020 Illegal beats SHALL be consumed and never selected.
REQ-021 Latency SHALL be: done asserted exactly one cycle after the cycle accepting the last beat; minimum start-to-done N_ACTIONS+1 cycles.
REQ-022 If no legal beat seen, done SHALL still pulse with no_legal=1, action=0, action_q=0.
REQ-023 action/action_q/no_legal SHALL update only at SCAN->DONE.

Reset
REQ-024 rst SHALL force IDLE from any state, including mid-SCAN, discarding partial scan.
REQ-025 Reset values SHALL be: q_ready=0, busy=0, done=0, action=0, action_q=0, no_legal=0, counter=0, best_valid=0.

Configuration
REQ-026 With POLICY_EPSILON_EN defined the module SHALL add input eps (8 bits) and output explored (1 bit) and epsilon-greedy selection; without it these ports SHALL be absent and selection purely greedy.
REQ-027 Under POLICY_EPSILON_EN a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) SHALL advance every cycle.
REQ-028 At accepted start, offset r = lfsr[IDX_WIDTH-1:0], minus N_ACTIONS if >= N_ACTIONS, SHALL be latched; explore decision = (eps==8'hFF) || (lfsr[15:8] < eps), latched same cycle.
REQ-029 During SCAN the module SHALL track the first legal index >= r, else first legal index overall, as explore candidate.
REQ-030 When explore is latched and a legal action exists, action/action_q SHALL take the explore candidate and explored=1; otherwise greedy result and explored=0; explored reset value 0.

Structure
REQ-031 Shared package policy_pkg SHALL hold FSM state encoding, default parameter values, LFSR seed and tap constants.
REQ-032 The LFSR SHALL be sub-module policy_lfsr, instantiated only under POLICY_EPSILON_EN.

Verification
REQ-033 All legal, Q={5,3,9,9,-2,0,1,7,4}, q_valid constant -> done 10 cycles after start cycle, action=2, action_q=9.
REQ-034 Same Q, legal=9'b1_1111_0011 (idx 2,3 illegal) -> action=7, action_q=7, no_legal=0.
REQ-035 legal=0 -> done pulses, no_legal=1, action=0, action_q=0.
REQ-036 q_valid low 3 cycles between every beat, all legal, Q all equal -16 -> action=0, done only after 9 accepted beats; start pulsed during SCAN ignored.
REQ-037 rst asserted after 4 accepted beats -> next cycle IDLE, all outputs at reset values; fresh start then gives correct result.
REQ-038 POLICY_EPSILON_EN: eps=0 -> results match REQ-033 with explored=0; eps=8'hFF, only idx 5 legal -> action=5, explored=1.

Source files
------------

// File: rtl/policy_pkg.sv
// policy_pkg -- shared definitions for the policy_select decision block.
//   state_t           : FSM state encoding for policy_select
//   DEF_*             : default parameter values
//   LFSR_SEED/TAPS    : reset seed and feedback taps of the exploration LFSR
package policy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_N_ACTIONS = 9;
    localparam int DEF_Q_WIDTH   = 16;
    localparam int DEF_IDX_WIDTH = 4;

    localparam int          LFSR_WIDTH = 16;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, left-shifting form: taps on bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage

// File: rtl/policy_lfsr.sv
// policy_lfsr -- free-running 16-bit Fibonacci LFSR used as the exploration
// random source. Advances every clock; reloads the seed on reset.
//   clk  : clock
//   rst  : synchronous active-high reset
//   lfsr : current LFSR state
import policy_pkg::*;

module policy_lfsr (
    input  logic                  clk,
    input  logic                  rst,
    output logic [LFSR_WIDTH-1:0] lfsr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/policy_select.sv
// policy_select -- streams N_ACTIONS Q-values and picks the best legal action
// (signed max, ties to lowest index).
//   clk, rst        : clock, synchronous active-high reset
//   start, legal    : request a decision with its legal-action mask
//   q_valid/q_data  : Q-value stream, index 0..N_ACTIONS-1; q_ready = accepting
//   busy, done      : scan in progress / one-cycle result strobe
//   action/action_q : selected index and its Q-value, held until next start
//   no_legal        : mask was all zero
// Optional build macro POLICY_EPSILON_EN adds epsilon-greedy exploration:
//   eps (in, 8b) exploration threshold, explored (out) result came from exploration.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | waiting for start
// SCAN    | consuming Q-value beats, tracking best/candidates
// DONE    | one-cycle result strobe, then back to IDLE
import policy_pkg::*;

module policy_select #(
    parameter int N_ACTIONS = DEF_N_ACTIONS,
    parameter int Q_WIDTH   = DEF_Q_WIDTH,
    parameter int IDX_WIDTH = DEF_IDX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_ACTIONS-1:0] legal,
    input  logic                 q_valid,
    input  logic [Q_WIDTH-1:0]   q_data,
    output logic                 q_ready,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_WIDTH-1:0] action,
    output logic [Q_WIDTH-1:0]   action_q,
    output logic                 no_legal
`ifdef POLICY_EPSILON_EN
    ,
    input  logic [7:0]           eps,
    output logic                 explored
`endif
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_ACTIONS - 1);

    state_t state, state_nxt;

    logic [N_ACTIONS-1:0]       legal_r;
    logic [IDX_WIDTH-1:0]       idx;
    logic                       best_valid;
    logic [IDX_WIDTH-1:0]       best_idx;
    logic signed [Q_WIDTH-1:0]  best_q;

    logic                       start_acc;
    logic                       beat_acc;
    logic                       beat_legal;
    logic                       last_beat;
    logic                       take_best;
    logic                       best_valid_nxt;
    logic [IDX_WIDTH-1:0]       best_idx_nxt;
    logic signed [Q_WIDTH-1:0]  best_q_nxt;
    logic [IDX_WIDTH-1:0]       sel_idx;
    logic [Q_WIDTH-1:0]         sel_q;

    // FSM
    always_comb begin
        state_nxt = state;
        q_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                q_ready = 1'b1;
                busy    = 1'b1;
                if (q_valid && idx == LAST_IDX) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign start_acc  = (state == ST_IDLE) && start;
    assign beat_acc   = q_valid && q_ready;
    assign beat_legal = legal_r[idx];
    assign last_beat  = beat_acc && (idx == LAST_IDX);

    // Greedy tracker including the beat being accepted this cycle, so the
    // final beat is folded in on the SCAN->DONE edge.
    assign take_best      = beat_acc && beat_legal &&
                            (!best_valid || $signed(q_data) > best_q);
    assign best_valid_nxt = best_valid || take_best;
    assign best_idx_nxt   = take_best ? idx : best_idx;
    assign best_q_nxt     = take_best ? $signed(q_data) : best_q;

`ifdef POLICY_EPSILON_EN
    logic [LFSR_WIDTH-1:0]     lfsr;
    logic [IDX_WIDTH-1:0]      r_raw;
    logic [IDX_WIDTH-1:0]      r_calc;
    logic                      explore_calc;
    logic [IDX_WIDTH-1:0]      r_off;
    logic                      explore_r;
    logic                      hi_valid, lo_valid;
    logic [IDX_WIDTH-1:0]      hi_idx, lo_idx;
    logic [Q_WIDTH-1:0]        hi_q, lo_q;
    logic                      take_hi, take_lo;
    logic                      sel_explored;

    policy_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    // Offset folded into 0..N_ACTIONS-1 with a single subtract; compared as
    // int so N_ACTIONS == 2**IDX_WIDTH does not wrap to zero.
    assign r_raw        = lfsr[IDX_WIDTH-1:0];
    assign r_calc       = (32'(r_raw) >= N_ACTIONS) ? r_raw - IDX_WIDTH'(N_ACTIONS) : r_raw;
    assign explore_calc = (eps == 8'hFF) || (lfsr[15:8] < eps);

    // hi: first legal index at or after the offset; lo: first legal overall
    // (wrap-around fallback).
    assign take_hi = beat_acc && beat_legal && !hi_valid && (idx >= r_off);
    assign take_lo = beat_acc && beat_legal && !lo_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_off     <= '0;
            explore_r <= 1'b0;
            hi_valid  <= 1'b0;
            lo_valid  <= 1'b0;
            hi_idx    <= '0;
            lo_idx    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            explored  <= 1'b0;
        end else if (start_acc) begin
            r_off     <= r_calc;
            explore_r <= explore_calc;
            hi_valid  <= 1'b0;
            lo_valid  <= 1'b0;
        end else begin
            if (take_hi) begin
                hi_valid <= 1'b1;
                hi_idx   <= idx;
                hi_q     <= q_data;
            end
            if (take_lo) begin
                lo_valid <= 1'b1;
                lo_idx   <= idx;
                lo_q     <= q_data;
            end
            if (last_beat) explored <= sel_explored;
        end
    end

    always_comb begin
        sel_idx      = best_idx_nxt;
        sel_q        = best_q_nxt;
        sel_explored = 1'b0;
        if (explore_r && best_valid_nxt) begin
            sel_explored = 1'b1;
            if (take_hi) begin
                sel_idx = idx;
                sel_q   = q_data;
            end else if (hi_valid) begin
                sel_idx = hi_idx;
                sel_q   = hi_q;
            end else if (take_lo) begin
                sel_idx = idx;
                sel_q   = q_data;
            end else begin
                sel_idx = lo_idx;
                sel_q   = lo_q;
            end
        end
    end
`else
    assign sel_idx = best_idx_nxt;
    assign sel_q   = best_q_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            legal_r    <= '0;
            idx        <= '0;
            best_valid <= 1'b0;
            best_idx   <= '0;
            best_q     <= '0;
            action     <= '0;
            action_q   <= '0;
            no_legal   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                legal_r    <= legal;
                idx        <= '0;
                best_valid <= 1'b0;
            end else if (beat_acc) begin
                idx        <= idx + 1'b1;
                best_valid <= best_valid_nxt;
                best_idx   <= best_idx_nxt;
                best_q     <= best_q_nxt;
                if (last_beat) begin
                    action   <= best_valid_nxt ? sel_idx : '0;
                    action_q <= best_valid_nxt ? sel_q : '0;
                    no_legal <= !best_valid_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_policy_select.sv
module tb_policy_select;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [8:0]         legal;
    logic               q_valid;
    logic [15:0]        q_data;
    logic               q_ready;
    logic               busy;
    logic               done;
    logic [3:0]         action;
    logic [15:0]        action_q;
    logic               no_legal;
    logic [7:0]         eps;
`ifdef POLICY_EPSILON_EN
    logic               explored;
`endif

    always #5 clk = ~clk;

    policy_select dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .legal    (legal),
        .q_valid  (q_valid),
        .q_data   (q_data),
        .q_ready  (q_ready),
        .busy     (busy),
        .done     (done),
        .action   (action),
        .action_q (action_q),
        .no_legal (no_legal)
`ifdef POLICY_EPSILON_EN
        ,
        .eps      (eps),
        .explored (explored)
`endif
    );

    typedef struct {
        logic [3:0]  act;
        logic [15:0] aq;
        logic        nl;
        logic        ex;
        int          lat;
    } exp_t;

    exp_t               sb[$];
    logic signed [15:0] qv [9];
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 cyc = 0;
    int                 start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Result checker: every done pulse must match the oldest pending decision.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("action",   32'(action),   32'(e.act));
                chk("action_q", 32'(action_q), 32'(e.aq));
                chk("no_legal", 32'(no_legal), 32'(e.nl));
                chk("latency",  32'(cyc - start_cyc), 32'(e.lat));
`ifdef POLICY_EPSILON_EN
                chk("explored", 32'(explored), 32'(e.ex));
`endif
            end
        end
    end

    // Called at posedge+1 with the DUT idle. gap = idle cycles between beats.
    task automatic run_decision(input logic [8:0] lg, input int gap, input bit mid_start,
                                input logic ex_exp, input logic [3:0] ex_act);
        exp_t e;
        bit   found = 0;
        e.act = '0;
        e.aq  = '0;
        for (int i = 0; i < 9; i++) begin
            if (lg[i] && (!found || qv[i] > $signed(e.aq))) begin
                found = 1;
                e.act = 4'(i);
                e.aq  = qv[i];
            end
        end
        e.nl  = !found;
        e.ex  = ex_exp;
        if (ex_exp) begin
            e.act = ex_act;
            e.aq  = qv[ex_act];
        end
        e.lat = 10 + gap * 8;
        sb.push_back(e);

        start     = 1'b1;
        legal     = lg;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("q_ready_scan", 32'(q_ready), 32'd1);
        chk("busy_scan",    32'(busy),    32'd1);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    q_valid = 1'b0;
                    start   = mid_start && (i == 4);
                    @(posedge clk); #1;
                end
                start = 1'b0;
            end
            q_valid = 1'b1;
            q_data  = qv[i];
            @(posedge clk); #1;
        end
        q_valid = 1'b0;
        for (int t = 0; t < 100 && sb.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic set_q_ref;
        qv = '{16'sd5, 16'sd3, 16'sd9, 16'sd9, -16'sd2, 16'sd0, 16'sd1, 16'sd7, 16'sd4};
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        legal   = '0;
        q_valid = 1'b0;
        q_data  = '0;
        eps     = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_q_ready",  32'(q_ready),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_action",   32'(action),   32'd0);
        chk("rst_action_q", 32'(action_q), 32'd0);
        chk("rst_no_legal", 32'(no_legal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // all legal: 9 at idx 2 and 3, tie goes to 2
        set_q_ref();
        run_decision(9'h1FF, 0, 1'b0, 1'b0, 4'd0);
        // idx 2,3 illegal -> 7
        run_decision(9'b1_1111_0011, 0, 1'b0, 1'b0, 4'd0);
        // negatives, tie at -3 between idx 1 and 6 -> 1
        qv = '{-16'sd5, -16'sd3, -16'sd9, -16'sd8, -16'sd4, -16'sd7, -16'sd3, -16'sd6, -16'sd9};
        run_decision(9'h1FF, 0, 1'b0, 1'b0, 4'd0);
        // only the last index legal
        run_decision(9'b1_0000_0000, 1, 1'b0, 1'b0, 4'd0);
        // stalls of 3 cycles, all -16, stray start while scanning
        foreach (qv[i]) qv[i] = -16'sd16;
        run_decision(9'h1FF, 3, 1'b1, 1'b0, 4'd0);
        // nothing legal
        set_q_ref();
        run_decision(9'h000, 0, 1'b0, 1'b0, 4'd0);

        // reset mid-scan after 4 accepted beats
        start = 1'b1;
        legal = 9'h1FF;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q_valid = 1'b1;
            q_data  = qv[i];
            @(posedge clk); #1;
        end
        q_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_q_ready",  32'(q_ready),  32'd0);
        chk("mid_rst_busy",     32'(busy),     32'd0);
        chk("mid_rst_done",     32'(done),     32'd0);
        chk("mid_rst_action",   32'(action),   32'd0);
        chk("mid_rst_action_q", 32'(action_q), 32'd0);
        chk("mid_rst_no_legal", 32'(no_legal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_decision(9'h1FF, 0, 1'b0, 1'b0, 4'd0);

`ifdef POLICY_EPSILON_EN
        eps = 8'h00;
        run_decision(9'h1FF, 0, 1'b0, 1'b0, 4'd0);
        qv[5] = 16'sd11;
        eps = 8'hFF;
        run_decision(9'b0_0010_0000, 0, 1'b0, 1'b1, 4'd5);
        eps = 8'h00;
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
